// File: rtl/uart_dtm_frame_tx_pkg.sv
// Shared definitions for the UART debug transport framing: command and
// register encodings, framing bytes and write-length helpers.
package uart_dtm_frame_tx_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_READ      = 3'd1,
        CMD_CONT_READ = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_RESET     = 3'd7
    } cmd_e;

    typedef enum logic [4:0] {
        ADDR_IDCODE  = 5'h01,
        ADDR_DTMCS   = 5'h10,
        ADDR_DMI     = 5'h11,
        ADDR_STB0_CS = 5'h14,
        ADDR_STB0_D  = 5'h15,
        ADDR_STB1_CS = 5'h16,
        ADDR_STB1_D  = 5'h17
    } addr_e;

    localparam logic [7:0] HEADER = 8'h01;
    localparam logic [7:0] ESC    = 8'hA0;

    typedef struct packed {
        cmd_e  cmd;
        addr_e addr;
    } cmd_byte_t;

    // Width in bits of the write payload for a register.
    function automatic int unsigned get_write_length(addr_e addr);
        case (addr)
            ADDR_IDCODE, ADDR_DTMCS, ADDR_STB0_D, ADDR_STB1_D: return 32;
            ADDR_DMI:                                          return 41;
            ADDR_STB0_CS, ADDR_STB1_CS:                        return 8;
            default:                                           return 8;
        endcase
    endfunction

    // Number of payload bytes sent for a write to this register.
    function automatic logic [2:0] get_write_bytes(addr_e addr);
        int unsigned len;
        len = get_write_length(addr);
        return 3'((len + 7) / 8);
    endfunction

endpackage

// File: rtl/uart_dtm_frame_tx_stuffer.sv
// Single-byte escape stuffer: inserts ESC ahead of any byte equal to HEADER
// or ESC unless bypassed. Combinational data path, one flag of state.
module uart_esc_stuffer
    import uart_dtm_frame_tx_pkg::*;
#(
    parameter int unsigned ESC_EN = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    input  logic       in_bypass_i,
    output logic       in_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i
);

    logic esc_pend_q, esc_pend_d;
    logic need_esc, send_esc;

    // Choose ESC or the raw byte; the upstream byte is consumed only when
    // the raw byte itself is accepted.
    always_comb begin
        need_esc    = (ESC_EN != 0) && !in_bypass_i &&
                      ((in_data_i == HEADER) || (in_data_i == ESC));
        send_esc    = need_esc && !esc_pend_q;
        out_data_o  = send_esc ? ESC : in_data_i;
        out_valid_o = in_valid_i;
        in_ready_o  = out_ready_i && !send_esc;
        esc_pend_d  = esc_pend_q;
        if (in_valid_i && out_ready_i) begin
            esc_pend_d = send_esc;
        end
    end

    // Escape-pending flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            esc_pend_q <= 1'b0;
        end else begin
            esc_pend_q <= esc_pend_d;
        end
    end

endmodule

// File: rtl/uart_dtm_frame_tx.sv
// Host-side frame encoder: HEADER, command byte, then the write payload
// LSB-first, passed through the escape stuffer to the UART TX byte port.
module uart_dtm_frame_tx
    import uart_dtm_frame_tx_pkg::*;
#(
    parameter int unsigned ESC_EN = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_cmd_i,
    input  logic [4:0]  req_addr_i,
    input  logic [40:0] req_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {StIdle, StHdr, StCmd, StData} state_e;

    state_e      state_q, state_d;
    cmd_e        cmd_q;
    addr_e       addr_q;
    logic [40:0] data_q;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    logic [2:0]  n_bytes;
    logic [47:0] data_ext;
    cmd_byte_t   cmd_byte;
    logic [7:0]  raw_data;
    logic        raw_valid, raw_bypass, raw_ready, raw_accept;
    logic        req_fire;

    assign req_ready_o = (state_q == StIdle) && !rst_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;

    // Raw byte source for the current state; payload bits above 40 read as 0.
    always_comb begin
        n_bytes       = (cmd_q == CMD_WRITE) ? get_write_bytes(addr_q) : 3'd0;
        data_ext      = {7'd0, data_q};
        cmd_byte.cmd  = cmd_q;
        cmd_byte.addr = addr_q;
        raw_data      = 8'h00;
        raw_valid     = 1'b0;
        raw_bypass    = 1'b0;
        unique case (state_q)
            StHdr: begin
                raw_data   = HEADER;
                raw_valid  = 1'b1;
                raw_bypass = 1'b1;
            end
            StCmd: begin
                raw_data  = cmd_byte;
                raw_valid = 1'b1;
            end
            StData: begin
                raw_data  = data_ext[{cnt_q, 3'b000} +: 8];
                raw_valid = 1'b1;
            end
            default: ;
        endcase
        raw_accept = raw_valid && raw_ready;
    end

    // Frame sequencing: next state, byte counter and done pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (raw_accept) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (raw_accept) begin
                    cnt_d = 3'd0;
                    if (n_bytes != 3'd0) begin
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StData: begin
                if (raw_accept) begin
                    if (cnt_q == n_bytes - 3'd1) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register and request latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            cmd_q   <= CMD_NOP;
            addr_q  <= addr_e'(5'd0);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (req_fire) begin
                cmd_q  <= cmd_e'(req_cmd_i);
                addr_q <= addr_e'(req_addr_i);
                data_q <= req_data_i;
            end
        end
    end

    uart_esc_stuffer #(
        .ESC_EN (ESC_EN)
    ) u_stuffer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (raw_data),
        .in_valid_i  (raw_valid),
        .in_bypass_i (raw_bypass),
        .in_ready_o  (raw_ready),
        .out_data_o  (tx_data_o),
        .out_valid_o (tx_valid_o),
        .out_ready_i (tx_ready_i)
    );

endmodule

// File: tb/tb_uart_dtm_frame_tx.sv
// Scoreboard bench for uart_dtm_frame_tx: directed frames plus randomized
// requests and backpressure against a byte-list reference model.
module tb_uart_dtm_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [4:0]  req_addr;
    logic [40:0] req_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    uart_dtm_frame_tx #(
        .ESC_EN (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_cmd_i   (req_cmd),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .busy_o      (busy),
        .done_o      (done)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: 3-cycle stall per byte

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h at %0t", name, got, req, $time);
        end
    endtask

    // Reference: header, command byte, payload bytes taken from the data word
    // arithmetically, every byte after the header escaped if it is 0x01/0xA0.
    function automatic bq_t model(input logic [2:0] cmd, input logic [4:0] addr,
                                  input logic [40:0] data);
        bq_t        q;
        logic [7:0] body[$];
        int         n;
        q.push_back(8'h01);
        body.push_back({cmd, addr});
        n = 0;
        if (cmd == 3'd3) begin
            case (addr)
                5'h01, 5'h10, 5'h15, 5'h17: n = 4;
                5'h11:                      n = 6;
                default:                    n = 1;
            endcase
        end
        for (int k = 0; k < n; k++) begin
            body.push_back(8'((data >> (8 * k)) & 41'hFF));
        end
        foreach (body[i]) begin
            if (body[i] == 8'h01 || body[i] == 8'hA0) q.push_back(8'hA0);
            q.push_back(body[i]);
        end
        return q;
    endfunction

    // TX ready driver.
    int stall_cnt = 0;
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!tx_valid) begin
                        tx_ready  = 1'b0;
                        stall_cnt = 0;
                    end else if (stall_cnt < 3) begin
                        tx_ready  = 1'b0;
                        stall_cnt++;
                    end else begin
                        tx_ready  = 1'b1;
                        stall_cnt = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each accepted byte and checks done,
    // stall stability and request gating.
    initial begin
        bit         prev_stall = 0;
        logic [7:0] prev_data  = 8'h00;
        bit         exp_done   = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                exp_done   = 0;
                prev_stall = 0;
            end else begin
                chk("done_pulse", done, exp_done);
                exp_done = 0;
                if (busy) chk("req_ready_while_busy", req_ready, 0);
                if (prev_stall) begin
                    chk("stall_valid_held", tx_valid, 1);
                    chk("stall_data_held", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte got=%0h required=none at %0t",
                                 tx_data, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("tx_byte", tx_data, e.b);
                        if (e.last) exp_done = 1;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    // Issue one request, queue its expected bytes, check header latency and
    // optionally wait for the frame to drain, returning busy cycles seen.
    task automatic send(input logic [2:0] cmd, input logic [4:0] addr, input logic [40:0] data,
                        input bq_t exp, input bit wait_done, output int busy_cycles);
        int   cyc;
        bit   ok;
        exp_t e;
        busy_cycles = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_data  = data;
        ok  = 0;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
            cyc++;
        end
        if (!ok) begin
            chk("handshake_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        foreach (exp[i]) begin
            e.b    = exp[i];
            e.last = (i == exp.size() - 1);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("hdr_valid_latency", tx_valid, 1);
        chk("hdr_data", tx_data, 8'h01);
        if (busy) busy_cycles++;
        if (wait_done) begin
            cyc = 0;
            while (busy || sbq.size() != 0) begin
                @(negedge clk);
                if (busy) busy_cycles++;
                cyc++;
                if (cyc > 400) begin
                    chk("frame_timeout", 0, 1);
                    sbq.delete();
                    break;
                end
            end
        end
    endtask

    initial begin
        bq_t         e;
        int          bc;
        logic [63:0] r;
        logic [2:0]  c;
        logic [4:0]  a;
        logic [4:0]  addrs[7];
        addrs = '{5'h01, 5'h10, 5'h11, 5'h14, 5'h15, 5'h16, 5'h17};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 3'd0;
        req_addr  = 5'd0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_tx_valid", tx_valid, 0);

        // Directed frames with the UART always ready.
        ready_mode = 0;
        e = {8'h01, 8'h30};
        send(3'd1, 5'h10, 41'd0, e, 1, bc);
        chk("read_dtmcs_cycles", bc, 2);
        e = {8'h01, 8'hA0, 8'h01};
        send(3'd0, 5'h01, 41'd0, e, 1, bc);
        chk("nop_idcode_cycles", bc, 3);
        e = {8'h01, 8'h75, 8'h03, 8'h02, 8'hA0, 8'hA0, 8'hA0, 8'h01};
        send(3'd3, 5'h15, 41'h01A00203, e, 1, bc);
        chk("write_stb0d_cycles", bc, 8);
        e = {8'h01, 8'h71, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA0, 8'h01};
        send(3'd3, 5'h11, 41'h1FF_FFFF_FFFF, e, 1, bc);
        chk("write_dmi_cycles", bc, 9);
        e = model(3'd5, 5'h01, 41'd0);
        send(3'd5, 5'h01, 41'd0, e, 1, bc);
        chk("unknown_cmd_cycles", bc, 2);

        // Backpressure on every byte of the STB0_D write.
        ready_mode = 2;
        e = {8'h01, 8'h75, 8'h03, 8'h02, 8'hA0, 8'hA0, 8'hA0, 8'h01};
        send(3'd3, 5'h15, 41'h01A00203, e, 1, bc);
        ready_mode = 0;

        // Reset while in the payload of a DMI write.
        e = model(3'd3, 5'h11, 41'h0AB_CDEF_1234);
        send(3'd3, 5'h11, 41'h0AB_CDEF_1234, e, 0, bc);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_req_ready", req_ready, 1);
        @(negedge clk);
        chk("abort_no_late_done", done, 0);
        e = {8'h01, 8'h21};
        send(3'd1, 5'h01, 41'd0, e, 1, bc);

        // Randomized requests under random backpressure.
        ready_mode = 1;
        repeat (40) begin
            r = {$urandom, $urandom};
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 3) == 0) r[8 * k +: 8] = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'hA0;
            end
            c = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'($urandom);
            a = ($urandom_range(0, 7) == 7) ? 5'($urandom) : addrs[$urandom_range(0, 6)];
            e = model(c, a, r[40:0]);
            send(c, a, r[40:0], e, 1, bc);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
